// File: rtl/modacc_frame.sv
// Frame accumulator: sums valid residues modulo MOD over FRAME_LEN samples (or until flush)
// and emits one registered result pulse per frame, together with the frame's sample count.
module modacc_frame #(
  parameter logic [34:0] MOD       = 35'h4_0008_0001,
  parameter int unsigned FRAME_LEN = 256,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_acc_vld,
  input  logic [34:0]      i_acc_din,
  input  logic             i_acc_flush,
  output logic             o_acc_vldout,
  output logic [34:0]      o_acc_dout,
  output logic [CNT_W-1:0] o_acc_len,
  output logic             o_acc_busy
);

  localparam int unsigned DW = 35;
  localparam int unsigned NW = CNT_W + 1;

  typedef enum logic {S_EMPTY, S_FILL} state_e;

  state_e           state_q, state_d;
  logic [DW-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             vldout_q, vldout_d;
  logic [DW-1:0]    dout_q, dout_d;
  logic [CNT_W-1:0] len_q, len_d;

  logic [DW-1:0]    x_c;
  logic [DW:0]      s_c;
  logic [DW-1:0]    r_c;
  logic [NW-1:0]    n_c;
  logic             close_c;

  // Pre-reduce the sample, add to the running sum, reduce once more; decide frame close.
  always_comb begin
    x_c      = (i_acc_din >= MOD) ? DW'(i_acc_din - MOD) : i_acc_din;
    s_c      = {1'b0, acc_q} + (i_acc_vld ? {1'b0, x_c} : (DW+1)'(0));
    r_c      = (s_c >= {1'b0, MOD}) ? DW'(s_c - {1'b0, MOD}) : DW'(s_c);
    n_c      = NW'(cnt_q) + NW'(i_acc_vld);
    close_c  = (i_acc_vld && (n_c == NW'(FRAME_LEN))) || (i_acc_flush && (n_c != '0));

    acc_d    = acc_q;
    cnt_d    = cnt_q;
    state_d  = state_q;
    vldout_d = 1'b0;
    dout_d   = '0;
    len_d    = '0;

    if (close_c) begin
      vldout_d = 1'b1;
      dout_d   = r_c;
      len_d    = CNT_W'(n_c);
      acc_d    = '0;
      cnt_d    = '0;
      state_d  = S_EMPTY;
    end else if (i_acc_vld) begin
      acc_d    = r_c;
      cnt_d    = CNT_W'(n_c);
      state_d  = S_FILL;
    end
  end

  // Single state/output register; reset discards any partial frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_EMPTY;
      acc_q    <= '0;
      cnt_q    <= '0;
      vldout_q <= 1'b0;
      dout_q   <= '0;
      len_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      vldout_q <= vldout_d;
      dout_q   <= dout_d;
      len_q    <= len_d;
    end
  end

  assign o_acc_vldout = vldout_q;
  assign o_acc_dout   = dout_q;
  assign o_acc_len    = len_q;
  assign o_acc_busy   = (state_q == S_FILL);

endmodule
